// File: rtl/debug_unit_if.sv
// Host-side bundle for debug_unit: UART rx/tx handshakes, pipeline status/control
// and the instruction-memory write port.
interface debug_unit_if #(
  parameter int LEN     = 32,
  parameter int NB_ADDR = 10
);
  logic               in_rx_done;
  logic [7:0]         in_rx_data;
  logic               in_tx_done;
  logic [LEN-1:0]     in_pc;
  logic               in_halt;
  logic               out_wr_en;
  logic [NB_ADDR-1:0] out_wr_addr;
  logic [LEN-1:0]     out_wr_data;
  logic               out_pipe_enable;
  logic               out_pipe_reset;
  logic               out_tx_start;
  logic [7:0]         out_tx_data;

  modport slave (
    input  in_rx_done, in_rx_data, in_tx_done, in_pc, in_halt,
    output out_wr_en, out_wr_addr, out_wr_data, out_pipe_enable,
           out_pipe_reset, out_tx_start, out_tx_data
  );

  modport master (
    output in_rx_done, in_rx_data, in_tx_done, in_pc, in_halt,
    input  out_wr_en, out_wr_addr, out_wr_data, out_pipe_enable,
           out_pipe_reset, out_tx_start, out_tx_data
  );
endinterface

// File: rtl/debug_unit.sv
// Host command decoder for the MIPS pipeline: loads instruction memory from UART bytes,
// runs or single-steps the pipeline, and reports the PC back over UART.
module debug_unit #(
  parameter int LEN     = 32,
  parameter int NB_ADDR = 10
) (
  input  logic        clk,
  input  logic        reset,
  debug_unit_if.slave bus
);
  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_NEXT = 8'h4E;
  localparam logic [7:0] CMD_END  = 8'h45;

  typedef enum logic [3:0] {
    IDLE, LOAD_CNT0, LOAD_CNT1, LOAD_WORD, WRITE,
    RUN, STEP_WAIT, STEP_PULSE, LATCH_PC, SEND_PC
  } state_t;

  state_t             state, next_state;
  logic [15:0]        count;
  logic [1:0]         byte_idx;
  logic [NB_ADDR-1:0] wr_addr;
  logic [LEN-1:0]     wr_data;
  logic [LEN-1:0]     pc_latch;
  logic               tx_wait;
  logic               from_run;
  logic               pipe_reset;
  logic               wr_en;
  logic               pipe_enable;
  logic               tx_start;

  always_comb begin
    next_state  = state;
    wr_en       = 1'b0;
    pipe_enable = 1'b0;
    tx_start    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_rx_done) begin
          case (bus.in_rx_data)
            CMD_LOAD: next_state = LOAD_CNT0;
            CMD_CONT: next_state = RUN;
            CMD_STEP: next_state = STEP_WAIT;
            default:  next_state = IDLE;
          endcase
        end
      end
      LOAD_CNT0: if (bus.in_rx_done) next_state = LOAD_CNT1;
      LOAD_CNT1: begin
        if (bus.in_rx_done)
          next_state = ({bus.in_rx_data, count[7:0]} == 16'd0) ? IDLE : LOAD_WORD;
      end
      LOAD_WORD: if (bus.in_rx_done && byte_idx == 2'd3) next_state = WRITE;
      WRITE: begin
        wr_en      = 1'b1;
        next_state = (count == 16'd1) ? IDLE : LOAD_WORD;
      end
      RUN: begin
        pipe_enable = 1'b1;
        if (bus.in_halt) next_state = LATCH_PC;
      end
      STEP_WAIT: begin
        if (bus.in_rx_done) begin
          if (bus.in_rx_data == CMD_NEXT)     next_state = STEP_PULSE;
          else if (bus.in_rx_data == CMD_END) next_state = IDLE;
        end
      end
      STEP_PULSE: begin
        pipe_enable = 1'b1;
        next_state  = LATCH_PC;
      end
      LATCH_PC: next_state = SEND_PC;
      SEND_PC: begin
        tx_start = !tx_wait;
        if (tx_wait && bus.in_tx_done && byte_idx == 2'd3)
          next_state = (from_run || bus.in_halt) ? IDLE : STEP_WAIT;
      end
      default: next_state = IDLE;
    endcase
  end

  // byte_idx is shared: it counts word bytes while loading and PC bytes while sending
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      byte_idx   <= '0;
      wr_addr    <= '0;
      wr_data    <= '0;
      pc_latch   <= '0;
      tx_wait    <= 1'b0;
      from_run   <= 1'b0;
      pipe_reset <= 1'b1;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (next_state == LOAD_CNT0) begin
            wr_addr    <= '0;
            pipe_reset <= 1'b1;
          end else if (next_state == RUN) begin
            pipe_reset <= 1'b0;
            from_run   <= 1'b1;
          end else if (next_state == STEP_WAIT) begin
            pipe_reset <= 1'b0;
            from_run   <= 1'b0;
          end
        end
        LOAD_CNT0: if (bus.in_rx_done) count[7:0] <= bus.in_rx_data;
        LOAD_CNT1: begin
          if (bus.in_rx_done) begin
            count[15:8] <= bus.in_rx_data;
            byte_idx    <= '0;
          end
        end
        LOAD_WORD: begin
          if (bus.in_rx_done) begin
            wr_data  <= {bus.in_rx_data, wr_data[LEN-1:8]};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        WRITE: begin
          wr_addr <= wr_addr + 1'b1;
          count   <= count - 16'd1;
        end
        LATCH_PC: begin
          pc_latch <= bus.in_pc;
          byte_idx <= '0;
          tx_wait  <= 1'b0;
        end
        SEND_PC: begin
          if (!tx_wait) begin
            tx_wait <= 1'b1;
          end else if (bus.in_tx_done) begin
            tx_wait  <= 1'b0;
            byte_idx <= byte_idx + 2'd1;
            pc_latch <= {8'h00, pc_latch[LEN-1:8]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_wr_en       = wr_en;
  assign bus.out_wr_addr     = wr_addr;
  assign bus.out_wr_data     = wr_data;
  assign bus.out_pipe_enable = pipe_enable;
  assign bus.out_pipe_reset  = pipe_reset;
  assign bus.out_tx_start    = tx_start;
  assign bus.out_tx_data     = pc_latch[7:0];
endmodule

// File: doc/debug_unit.md
# debug_unit

Host-side control block that sits upstream of the five-stage MIPS pipeline. It receives byte commands from a UART receiver and assembles 32-bit words for instruction memory. It gates the pipeline through a global enable and reset, running it either continuously until halt or one cycle per step. After each run or step it returns the current PC to the host through a UART transmitter.

## Interface
Parameters:
- `LEN`, 32, data/instruction word width in bits; must be 32.
- `NB_ADDR`, 10, instruction-memory word-address width.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_rx_done`  in  1  one-cycle pulse; `in_rx_data` is valid.
- `in_rx_data`  in  8  received byte.
- `in_tx_done`  in  1  one-cycle pulse; transmitter finished the current byte.
- `in_pc`  in  LEN  current PC from the fetch stage.
- `in_halt`  in  1  pipeline has retired a halt instruction (level).
- `out_wr_en`  out  1  instruction-memory write strobe.
- `out_wr_addr`  out  NB_ADDR  word address.
- `out_wr_data`  out  LEN  word to write.
- `out_pipe_enable`  out  1  clock enable to all pipeline stages.
- `out_pipe_reset`  out  1  synchronous reset to all pipeline stages.
- `out_tx_start`  out  1  one-cycle pulse; start sending `out_tx_data`.
- `out_tx_data`  out  8  byte to send.

## Operation
- FSM states: IDLE, LOAD_CNT0, LOAD_CNT1, LOAD_WORD, WRITE, RUN, STEP_WAIT, STEP_PULSE, LATCH_PC, SEND_PC.
- IDLE accepts these commands, one per `in_rx_done`:
  - 0x4C 'L' → LOAD_CNT0.
  - 0x43 'C' → RUN.
  - 0x53 'S' → STEP_WAIT.
  - Any other byte is ignored and the FSM stays in IDLE.
- Load sequence:
  - LOAD_CNT0 captures count bits [7:0]; LOAD_CNT1 captures bits [15:8] (N, little-endian).
  - `out_wr_addr` is cleared to 0 on entering LOAD_CNT0.
  - If N=0: return to IDLE with no writes.
  - Otherwise LOAD_WORD collects 4 bytes, LSB first, into `out_wr_data`.
  - After the 4th byte, WRITE pulses `out_wr_en` for one cycle, then increments `out_wr_addr` (modulo 2^NB_ADDR; wraps silently) and decrements the remaining count.
  - When the count reaches 0 the FSM returns to IDLE; otherwise it goes back to LOAD_WORD.
- `out_pipe_reset`:
  - Set to 1 by `reset` and on entering LOAD_CNT0.
  - Cleared to 0 on entering RUN or STEP_WAIT.
  - Otherwise holds its value.
- RUN:
  - `out_pipe_enable`=1 every cycle; rx bytes are ignored.
  - When `in_halt` is sampled 1, enable drops to 0 on the next cycle and the FSM goes to LATCH_PC.
- STEP_WAIT (`out_pipe_enable`=0):
  - 0x4E 'N' → STEP_PULSE: enable=1 for exactly one cycle, then LATCH_PC.
  - 0x45 'E' → IDLE.
  - Other bytes are ignored.
- LATCH_PC registers `in_pc`. SEND_PC then sends its 4 bytes, LSB first.
- Exit from SEND_PC after the 4th `in_tx_done`:
  - To IDLE if the run came from RUN, or if `in_halt`=1.
  - Otherwise to STEP_WAIT.

## Timing
- Reset values:
  - `out_pipe_reset`=1.
  - `out_pipe_enable`, `out_wr_en`, `out_tx_start` = 0.
  - `out_wr_addr`, `out_wr_data`, `out_tx_data` = 0.
  - FSM in IDLE; count and PC latch cleared.
- `reset` mid-operation aborts any load or transmission immediately. Partial words are discarded and no write occurs.
- Command latency: the state changes on the cycle after the `in_rx_done` edge.
  - Example: 'C' sampled at edge k gives `out_pipe_enable`=1 from cycle k+1.
- Write latency: the 4th byte's `in_rx_done` at edge k gives `out_wr_en`=1 during cycle k+1, with stable addr/data. The address increments at edge k+2.
- Step: exactly one cycle of enable per 'N'. The PC is latched the cycle after the enable cycle, so it reflects the post-step PC.
- TX handshake:
  - `out_tx_start` pulses one cycle with `out_tx_data` stable, and `out_tx_data` holds until `in_tx_done`.
  - The next start is issued the cycle after `in_tx_done`.
  - `in_tx_done` outside SEND_PC is ignored.
- `in_halt` is ignored in IDLE and in the load states.
- An `in_rx_done` coinciding with the transition into RUN is ignored.

## Test plan
- Load: send 'L',0x02,0x00, then bytes 78 56 34 12 and EF BE AD DE.
  - `out_wr_en` pulses twice: addr 0 with 0x12345678, and addr 1 with 0xDEADBEEF.
  - Final state IDLE with `out_pipe_reset`=1.
- Zero-count load: send 'L',0x00,0x00, then 'C'.
  - No `out_wr_en` pulse.
  - `out_pipe_reset` falls and `out_pipe_enable` rises one cycle after 'C'.
- Run to halt: after 'C', hold `in_pc`=0x00000020 and assert `in_halt` at cycle 10.
  - Enable is 0 from cycle 11.
  - TX bytes are 20 00 00 00, each start issued only after the previous `in_tx_done`.
  - FSM returns to IDLE.
- Step:
  - Send 'S', then 'N' three times, with `in_pc` advancing by 4 per enabled cycle from 0.
  - Exactly three single-cycle enables.
  - Reports 0x04, 0x08, 0x0C, LSB first.
  - 'E' returns the FSM to IDLE.
- Reset mid-load: assert `reset` after 2 bytes of the first word.
  - No write occurs; all outputs return to reset values.
  - A following 'L' load restarts at addr 0.
- Wrap and noise: with NB_ADDR=2, load 5 words.
  - The 5th write goes to addr 0.
  - Byte 0x41 in IDLE and bytes received during RUN cause no state change.
